// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a palette-index sprite from ROM into a 320x240 frame buffer with screen clipping.
// Define SPRITE_BLITTER_TRANSPARENCY_EN to suppress writes of TRANSPARENT_IDX pixels.
`default_nettype none

module sprite_blitter #(
  parameter int SCREEN_W        = 320,
  parameter int SCREEN_H        = 240,
  parameter int FB_ADDR_W       = 19,
  parameter int PIX_W           = 5,
  parameter int SPR_ADDR_W      = 16,
  parameter int DIM_W           = 7,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  start,
  input  logic [SPR_ADDR_W-1:0] spr_base,
  input  logic [DIM_W-1:0]      spr_w,
  input  logic [DIM_W-1:0]      spr_h,
  input  logic [9:0]            dst_x,
  input  logic [9:0]            dst_y,
  output logic                  busy,
  output logic                  done,
  output logic [SPR_ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]      rom_data,
  output logic                  fb_we,
  output logic [FB_ADDR_W-1:0]  fb_addr,
  output logic [PIX_W-1:0]      fb_data
);

  localparam int PAD_W = FB_ADDR_W - 11;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   load, advance, zero_size, last_pix;
  logic                   skip, x_ok, y_ok, wr;
  logic [DIM_W-1:0]       w_q, h_q, col, row;
  logic [9:0]             x0, y0;
  logic                   drain_last;
  logic                   s1_valid, s2_valid;
  logic [10:0]            s2_x, s2_y;
  logic [FB_ADDR_W-1:0]   x_ext, y_ext;

  assign zero_size = (spr_w == '0) || (spr_h == '0);
  assign last_pix  = (col == w_q - DIM_W'(1)) && (row == h_q - DIM_W'(1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // A zero-size command spends its single busy cycle in DRAIN with the drain already complete.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = zero_size ? DRAIN : FETCH;
          load      = !zero_size;
        end
      end
      FETCH: begin
        if (last_pix) state_nxt = DRAIN;
        else          advance   = 1'b1;
      end
      DRAIN:   if (drain_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy = (state == FETCH) || (state == DRAIN);
    done = (state == DONE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      w_q        <= '0;
      h_q        <= '0;
      x0         <= '0;
      y0         <= '0;
      col        <= '0;
      row        <= '0;
      drain_last <= 1'b0;
      rom_addr   <= '0;
      s1_valid   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        w_q        <= spr_w;
        h_q        <= spr_h;
        x0         <= dst_x;
        y0         <= dst_y;
        col        <= '0;
        row        <= '0;
        drain_last <= zero_size;
      end
      if (state == DRAIN) drain_last <= 1'b1;
      if (load) rom_addr <= spr_base;
      if (advance) begin
        rom_addr <= rom_addr + SPR_ADDR_W'(1);
        if (col == w_q - DIM_W'(1)) begin
          col <= '0;
          row <= row + DIM_W'(1);
        end else begin
          col <= col + DIM_W'(1);
        end
      end
      // col/row always name the pixel currently on rom_addr
      s1_valid <= load | advance;
    end
  end

  // Stage 2 lines up with rom_data: screen coordinates of the pixel arriving from ROM.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_valid <= 1'b0;
      s2_x     <= '0;
      s2_y     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_x     <= {x0[9], x0} + 11'(col);
      s2_y     <= {y0[9], y0} + 11'(row);
    end
  end

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  assign skip = (rom_data == PIX_W'(TRANSPARENT_IDX));
`else
  // Index compare kept but masked so the parameter stays referenced in this build.
  assign skip = 1'b0 & (rom_data == PIX_W'(TRANSPARENT_IDX));
`endif

  assign x_ok  = !s2_x[10] && (s2_x < 11'(SCREEN_W));
  assign y_ok  = !s2_y[10] && (s2_y < 11'(SCREEN_H));
  assign wr    = s2_valid && x_ok && y_ok && !skip;
  assign x_ext = {{PAD_W{1'b0}}, s2_x};
  assign y_ext = {{PAD_W{1'b0}}, s2_y};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= wr;
      if (wr) begin
        fb_addr <= (y_ext << 8) + (y_ext << 6) + x_ext;
        fb_data <= rom_data;
      end
    end
  end

endmodule

`default_nettype wire
